// File: rtl/writeback_unit.sv
// Register-file write-side initiator: merges ALU and load results into a small
// in-order FIFO, drains one write per cycle and reports per-register pending writes.
module writeback_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [4:0]            mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  rf_wr,
    output logic [4:0]            rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wd,
    input  logic [4:0]            chk_rs1,
    input  logic [4:0]            chk_rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  empty,
    output logic [PTR_W:0]        count
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    logic [4:0]            ent_rd_q [DEPTH];
    logic [DATA_WIDTH-1:0] ent_wd_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  rf_wr_q, rf_wr_d;
    logic [4:0]            rf_rd_q, rf_rd_d;
    logic [DATA_WIDTH-1:0] rf_wd_q, rf_wd_d;

    logic                  full_s;
    logic                  push_s;
    logic                  store_s;
    logic                  pop_s;
    logic [4:0]            push_rd_s;
    logic [DATA_WIDTH-1:0] push_wd_s;
    logic [DEPTH-1:0]      occupied_s;
    logic [DEPTH-1:0]      match1_s;
    logic [DEPTH-1:0]      match2_s;

    // Readiness: a full FIFO refuses regardless of a same-cycle pop; ALU has priority.
    always_comb begin
        full_s    = (count_q == DEPTH_C);
        alu_ready = !full_s;
        mem_ready = !full_s && !alu_valid;
    end

    // Select the single accepted source this cycle.
    always_comb begin
        push_s    = 1'b0;
        push_rd_s = 5'd0;
        push_wd_s = '0;
        if (alu_valid && alu_ready) begin
            push_s    = 1'b1;
            push_rd_s = alu_rd;
            push_wd_s = alu_data;
        end else if (mem_valid && mem_ready) begin
            push_s    = 1'b1;
            push_rd_s = mem_rd;
            push_wd_s = mem_data;
        end else begin
            push_s    = 1'b0;
        end
        // x0 writes complete the handshake but are never stored
        store_s = push_s && (push_rd_s != 5'd0);
        pop_s   = (count_q != '0);
    end

    // Pointer, occupancy and write-port next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rf_wr_d  = 1'b0;
        rf_rd_d  = rf_rd_q;
        rf_wd_d  = rf_wd_q;
        if (store_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rf_wr_d  = 1'b1;
            rf_rd_d  = ent_rd_q[rd_ptr_q];
            rf_wd_d  = ent_wd_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            rf_wr_d  = 1'b0;
        end
        case ({store_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control and write-port registers; reset discards anything pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rf_wr_q  <= 1'b0;
            rf_rd_q  <= 5'd0;
            rf_wd_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rf_wr_q  <= rf_wr_d;
            rf_rd_q  <= rf_rd_d;
            rf_wd_q  <= rf_wd_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i] <= 5'd0;
                ent_wd_q[i] <= '0;
            end
        end else if (store_s) begin
            ent_rd_q[wr_ptr_q] <= push_rd_s;
            ent_wd_q[wr_ptr_q] <= push_wd_s;
        end
    end

    // Per-entry occupancy (distance from head below count) and source matches.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset     = '0;
        occupied_s = '0;
        match1_s   = '0;
        match2_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset        = PTR_W'(i) - rd_ptr_q;
            occupied_s[i] = ({1'b0, offset} < count_q);
            match1_s[i]   = (ent_rd_q[i] == chk_rs1);
            match2_s[i]   = (ent_rd_q[i] == chk_rs2);
        end
    end

    // Pending flags cover queued entries plus the write on the port this cycle.
    always_comb begin
        busy1 = (chk_rs1 != 5'd0) &&
                ((|(occupied_s & match1_s)) || (rf_wr_q && (rf_rd_q == chk_rs1)));
        busy2 = (chk_rs2 != 5'd0) &&
                ((|(occupied_s & match2_s)) || (rf_wr_q && (rf_rd_q == chk_rs2)));
        empty = (count_q == '0) && !rf_wr_q;
    end

    assign rf_wr = rf_wr_q;
    assign rf_rd = rf_rd_q;
    assign rf_wd = rf_wd_q;
    assign count = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed table-driven bench for writeback_unit plus burst and reset sequences.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd, mem_rd, chk_rs1, chk_rs2, rf_rd;
    logic [31:0] alu_data, mem_data, rf_wd;
    logic        rf_wr, busy1, busy2, empty;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_unit #(.DATA_WIDTH(32), .DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy1(busy1), .busy2(busy2),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        e_ar;
        logic        e_mr;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_b1;
        logic        e_b2;
        logic        e_em;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic [4:0] c1, input logic [4:0] c2,
                                input logic ear, input logic emr, input logic ewr,
                                input logic [4:0] erd, input logic [31:0] ewd,
                                input logic eb1, input logic eb2, input logic eem,
                                input logic [2:0] ecnt);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
        v.c1 = c1; v.c2 = c2; v.e_ar = ear; v.e_mr = emr; v.e_wr = ewr;
        v.e_rd = erd; v.e_wd = ewd; v.e_b1 = eb1; v.e_b2 = eb2; v.e_em = eem; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // each row: inputs for one cycle, expected outputs sampled mid-cycle
        tbl[0]  = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 1'b1, 3'd0);
        tbl[1]  = mk(1'b1, 5'd1, 32'd15, 1'b0, 5'd0, 32'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 1'b1, 3'd0);
        tbl[2]  = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, 3'd1);
        tbl[3]  = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd1, 32'd15, 1'b1, 1'b0, 1'b0, 3'd0);
        tbl[4]  = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd1, 32'd15, 1'b0, 1'b0, 1'b1, 3'd0);
        tbl[5]  = mk(1'b1, 5'd2, 32'd7,  1'b1, 5'd5, 32'd9, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 5'd1, 32'd15, 1'b0, 1'b0, 1'b1, 3'd0);
        tbl[6]  = mk(1'b0, 5'd0, 32'd0,  1'b1, 5'd5, 32'd9, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 5'd1, 32'd15, 1'b1, 1'b0, 1'b0, 3'd1);
        tbl[7]  = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 32'd7,  1'b1, 1'b1, 1'b0, 3'd1);
        tbl[8]  = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 32'd9,  1'b0, 1'b1, 1'b0, 3'd0);
        tbl[9]  = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 32'd9,  1'b0, 1'b0, 1'b1, 3'd0);
        tbl[10] = mk(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 32'd9, 1'b0, 1'b0, 1'b1, 3'd0);
        tbl[11] = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'd9,  1'b0, 1'b0, 1'b1, 3'd0);
        tbl[12] = mk(1'b0, 5'd0, 32'd0,  1'b1, 5'd0, 32'h55, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'd9, 1'b0, 1'b0, 1'b1, 3'd0);
        tbl[13] = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'd9,  1'b0, 1'b0, 1'b1, 3'd0);
        tbl[14] = mk(1'b1, 5'd3, 32'd10, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 32'd9,  1'b0, 1'b0, 1'b1, 3'd0);
        tbl[15] = mk(1'b1, 5'd3, 32'd20, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 32'd9,  1'b1, 1'b0, 1'b0, 3'd1);
        tbl[16] = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'd10, 1'b1, 1'b0, 1'b0, 3'd1);
        tbl[17] = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'd20, 1'b1, 1'b0, 1'b0, 3'd0);
        tbl[18] = mk(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 5'd3, 32'd20, 1'b0, 1'b0, 1'b1, 3'd0);

        rst_n = 1'b0;
        idle();
        chk_rs1 = 5'd0;
        chk_rs2 = 5'd0;
        #2;
        chk("reset_rf_wr", {31'd0, rf_wr}, 32'd0);
        chk("reset_count", {29'd0, count}, 32'd0);
        chk("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("reset_rf_wd", rf_wd, 32'd0);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].md;
            chk_rs1 = tbl[i].c1; chk_rs2 = tbl[i].c2;
            @(negedge clk);
            chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, tbl[i].e_ar});
            chk($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, tbl[i].e_mr});
            chk($sformatf("v%0d_rf_wr", i),     {31'd0, rf_wr},     {31'd0, tbl[i].e_wr});
            chk($sformatf("v%0d_rf_rd", i),     {27'd0, rf_rd},     {27'd0, tbl[i].e_rd});
            chk($sformatf("v%0d_rf_wd", i),     rf_wd,              tbl[i].e_wd);
            chk($sformatf("v%0d_busy1", i),     {31'd0, busy1},     {31'd0, tbl[i].e_b1});
            chk($sformatf("v%0d_busy2", i),     {31'd0, busy2},     {31'd0, tbl[i].e_b2});
            chk($sformatf("v%0d_empty", i),     {31'd0, empty},     {31'd0, tbl[i].e_em});
            chk($sformatf("v%0d_count", i),     {29'd0, count},     {29'd0, tbl[i].e_cnt});
            next_cycle();
        end

        // Burst of 5 back-to-back ALU results while draining.
        chk_rs1 = 5'd0;
        chk_rs2 = 5'd0;
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c < 5) begin
                alu_valid = 1'b1;
                alu_rd    = 5'(10 + c);
                alu_data  = 32'(100 + c);
            end
            @(negedge clk);
            chk($sformatf("burst%0d_alu_ready", c), {31'd0, alu_ready}, 32'd1);
            chk($sformatf("burst%0d_ready_vs_full", c), {31'd0, alu_ready}, {31'd0, (count != 3'd4)});
            chk($sformatf("burst%0d_count_le4", c), {31'd0, (count <= 3'd4)}, 32'd1);
            chk($sformatf("burst%0d_count", c), {29'd0, count},
                (c >= 1 && c <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("burst%0d_rf_wr", c), {31'd0, rf_wr},
                (c >= 2 && c <= 6) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 6) begin
                chk($sformatf("burst%0d_rf_rd", c), {27'd0, rf_rd}, 32'(10 + c - 2));
                chk($sformatf("burst%0d_rf_wd", c), rf_wd, 32'(100 + c - 2));
            end
            next_cycle();
        end

        // Reset asserted mid-drain: discards pending writes asynchronously.
        chk_rs1 = 5'd8;
        for (int c = 0; c < 3; c++) begin
            idle();
            alu_valid = 1'b1;
            alu_rd    = 5'(6 + c);
            alu_data  = 32'(1 + c);
            next_cycle();
        end
        idle();
        #1;
        chk("pre_reset_rf_wr", {31'd0, rf_wr}, 32'd1);
        chk("pre_reset_count", {29'd0, count}, 32'd1);
        chk("pre_reset_busy1", {31'd0, busy1}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_rf_wr", {31'd0, rf_wr}, 32'd0);
        chk("async_reset_count", {29'd0, count}, 32'd0);
        chk("async_reset_empty", {31'd0, empty}, 32'd1);
        chk("async_reset_busy1", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_reset%0d_rf_wr", c), {31'd0, rf_wr}, 32'd0);
            chk($sformatf("post_reset%0d_empty", c), {31'd0, empty}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
